inv_key_expander: RTL and testbench
===================================

# inv_key_expander

Iterative AES-128 inverse key expander: loads the round-10 key and walks the schedule backwards, emitting round keys 10, 9, …, 0 in the order the decryption datapath consumes them. It is the reverse-direction counterpart of the forward per-round expansion stage. It sits between the key-load logic and the inverse-cipher round engine. It uses a valid/ready output handshake so that it never has to store all 11 round keys.

## Interface
- No parameters; AES-128 only, 10 rounds fixed.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- key_in  in  128  round-10 key; word0 = [127:96] … word3 = [31:0]; sampled with start
- out_ready  in  1  consumer accepts out_key this cycle
- out_valid  out  1  out_key/out_round hold a valid round key
- out_key  out  128  current round key, same word order as key_in
- out_round  out  4  round index of out_key, 10 down to 0
- busy  out  1  high from the cycle after start until the round-0 key is accepted
- done  out  1  one-cycle pulse when the round-0 key is accepted

## Operation
- State machine IDLE -> EMIT -> IDLE.
- Registers: key_r[127:0], round_r[3:0], state, done_r.
- IDLE, start=1: key_r <= key_in, round_r <= 10, state <= EMIT. start=0: hold.
- EMIT: out_valid=1, out_key=key_r, out_round=round_r, busy=1.
- EMIT, out_ready=1 and round_r>0: key_r <= prev(key_r, round_r), round_r <= round_r-1, stay in EMIT.
- EMIT, out_ready=1 and round_r=0: state <= IDLE, done pulses for one cycle, out_valid drops the same edge.
- EMIT, out_ready=0: key_r and round_r hold; out_key/out_round must stay stable while out_valid is high.
- prev(w0,w1,w2,w3 ; r) is the previous-round key:
  - p3 = w3^w2, p2 = w2^w1, p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
- RotWord(a,b,c,d) = (b,c,d,a), byte a = [31:24]. SubWord applies the forward AES S-box to each byte (four S-box instances, combinational).
- Rcon[r] for r=1..10: 01,02,04,08,10,20,40,80,1b,36. Rcon for r=0 is never used.
- start while busy: ignored, with no effect on the sequence.
- round_r never wraps below 0; decrement happens only when round_r>0.
- out_key is driven from key_r only; the next-key logic never drives it combinationally.

## Timing
- Reset values: state=IDLE, out_valid=0, busy=0, done=0, out_key=128'h0, out_round=4'h0.
- start at edge N -> out_valid=1 and out_round=10 after edge N.
- With out_ready held high, one key is emitted per cycle: 11 consecutive valid cycles. done pulses in the cycle after the round-0 handshake.
- start is sampled in IDLE, including the cycle right after done. Minimum start-to-start spacing is 12 cycles.
- The inverse round is one combinational stage, register to register: XOR, S-box, XOR.
- rst_n low at any time, including mid-sequence: asynchronously forces all reset values. The sequence is abandoned and no done is produced.
- done and out_valid are never high in the same cycle.

## Test plan
- FIPS-197 A.1 sequence: start with key_in=d014f9a8c9ee2589e13f0cc8b6630ca6, out_ready=1.
  - Round 10 key = key_in.
  - Round 9 = ac7766f319fadc2128d12941575c006e.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - done one cycle after round 0; 11 valid cycles total.
- Backpressure: same vector with out_ready toggled pseudo-randomly. out_key/out_round stay stable while out_valid=1 and out_ready=0. The sequence matches the first test exactly.
- Start while busy: pulse start with a different key_in at round 6. The sequence continues unchanged to round 0 with the original key.
- Reset mid-op: drop rst_n during round 4. Outputs go to reset values immediately and no done appears. A later start runs a clean full sequence.
- Round-trip: random 128-bit key expanded with the forward expander to round 10, then fed here. Round 0 output equals the original key, and every intermediate key matches the forward schedule. At least 1000 keys.
- Back-to-back: start asserted in the cycle after done. The new sequence begins with out_round=10 one cycle later.

Source files
------------

// File: rtl/inv_key_expander.sv
// AES-128 inverse key expander: loads the round-10 key and walks the schedule
// backwards, presenting round keys 10..0 over a valid/ready handshake.
module inv_key_expander (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [127:0] out_key,
    output logic [3:0]   out_round,
    output logic         busy,
    output logic         done
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    // Forward AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_FLAT = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Byte b sits at bit offset (255-b)*8, and 255-b is simply ~b.
        sbox = SBOX_FLAT[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    state_t       state, state_nx;
    logic [127:0] key_r, key_nx;
    logic [3:0]   round_r, round_nx;
    logic         done_r, done_nx;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  p0, p1, p2, p3;
    logic [31:0]  rot, sub;
    logic [127:0] key_prev;

    assign w0 = key_r[127:96];
    assign w1 = key_r[95:64];
    assign w2 = key_r[63:32];
    assign w3 = key_r[31:0];

    // Undo the forward XOR chain first; p3 is then the word the forward step rotated.
    assign p3  = w3 ^ w2;
    assign p2  = w2 ^ w1;
    assign p1  = w1 ^ w0;
    assign rot = {p3[23:0], p3[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign p0  = w0 ^ sub ^ {rcon(round_r), 24'h0};

    assign key_prev = {p0, p1, p2, p3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_r   <= '0;
            round_r <= '0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            key_r   <= key_nx;
            round_r <= round_nx;
            done_r  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        key_nx   = key_r;
        round_nx = round_r;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    key_nx   = key_in;
                    round_nx = 4'd10;
                    state_nx = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (round_r == 4'd0) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        key_nx   = key_prev;
                        round_nx = round_r - 4'd1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign done      = done_r;
    assign out_key   = key_r;
    assign out_round = round_r;

endmodule

// File: tb/tb_inv_key_expander.sv
// Directed and round-trip bench for inv_key_expander against a forward
// AES-128 key schedule model built from a GF(2^8)-derived S-box.
module tb_inv_key_expander;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] out_key;
    logic [3:0]   out_round;
    logic         busy;
    logic         done;

    int n_tests;
    int n_fail;

    logic [7:0]   tb_sbox [0:255];
    logic [127:0] rk  [0:10];
    logic [127:0] got [0:10];

    inv_key_expander dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .key_in    (key_in),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_key   (out_key),
        .out_round (out_round),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, p;
        x = a;
        y = b;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            tb_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward schedule: rk[r] is the round-r key derived from cipher key k0.
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {tb_sbox[t[31:24]], tb_sbox[t[23:16]], tb_sbox[t[15:8]], tb_sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Drives one sequence from a negedge, checking each key against rk[].
    task automatic run_seq(input logic [127:0] k10, input bit bp, input int inj_round,
                           input int rst_round, input bit skip_start, input bit b2b,
                           input logic [127:0] b2b_key);
        int r;
        int cyc;
        bit rdy;
        r = 10;
        cyc = 0;
        if (!skip_start) begin
            start  = 1'b1;
            key_in = k10;
            @(negedge clk);
            start  = 1'b0;
        end
        check("first_valid", 128'(out_valid), 128'd1);
        check("first_round", 128'(out_round), 128'd10);
        while (r >= 0) begin
            cyc++;
            if (cyc > 400) begin
                check("timeout", 128'(cyc), 128'd0);
                return;
            end
            check("valid", 128'(out_valid), 128'd1);
            check("busy", 128'(busy), 128'd1);
            check("done_low", 128'(done), 128'd0);
            check("round", 128'(out_round), 128'(r));
            check("key", out_key, rk[r]);
            got[r] = out_key;
            if (rst_round == r) begin
                rst_n = 1'b0;
                #1;
                check("rst_valid", 128'(out_valid), 128'd0);
                check("rst_busy", 128'(busy), 128'd0);
                check("rst_done", 128'(done), 128'd0);
                check("rst_key", out_key, 128'h0);
                check("rst_round", 128'(out_round), 128'd0);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rst_no_done", 128'(done), 128'd0);
                    check("rst_idle", 128'(out_valid), 128'd0);
                end
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = rdy;
            if (inj_round == r) begin
                start  = 1'b1;
                key_in = ~k10;
            end
            @(negedge clk);
            start = 1'b0;
            if (rdy) r--;
        end
        check("done_pulse", 128'(done), 128'd1);
        check("end_valid", 128'(out_valid), 128'd0);
        check("end_busy", 128'(busy), 128'd0);
        out_ready = 1'b0;
        if (b2b) begin
            start  = 1'b1;
            key_in = b2b_key;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_once", 128'(done), 128'd0);
    endtask

    logic [127:0] k2_10;

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        key_in    = '0;
        build_sbox();
        repeat (2) @(negedge clk);
        check("reset_valid", 128'(out_valid), 128'd0);
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_key", out_key, 128'h0);
        check("reset_round", 128'(out_round), 128'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_valid", 128'(out_valid), 128'd0);

        // FIPS-197 A.1 walked backwards
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, -1, -1, 1'b0, 1'b0, '0);
        check("fips_r10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_r9",  got[9],  128'hac7766f319fadc2128d12941575c006e);
        check("fips_r1",  got[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_r0",  got[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Backpressure
        run_seq(128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1, -1, -1, 1'b0, 1'b0, '0);
        check("bp_r9", got[9], 128'hac7766f319fadc2128d12941575c006e);
        check("bp_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Start while busy
        run_seq(rk[10], 1'b0, 6, -1, 1'b0, 1'b0, '0);
        check("busy_start_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Reset mid-sequence, then a clean run
        run_seq(rk[10], 1'b0, -1, 4, 1'b0, 1'b0, '0);
        run_seq(rk[10], 1'b0, -1, -1, 1'b0, 1'b0, '0);
        check("post_rst_r0", got[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);

        // Back-to-back: second start in the cycle done is high
        expand(128'h000102030405060708090a0b0c0d0e0f);
        k2_10 = rk[10];
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        run_seq(rk[10], 1'b0, -1, -1, 1'b0, 1'b1, k2_10);
        expand(128'h000102030405060708090a0b0c0d0e0f);
        run_seq(k2_10, 1'b0, -1, -1, 1'b1, 1'b0, '0);
        check("b2b_r10", got[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        check("b2b_r0", got[0], 128'h000102030405060708090a0b0c0d0e0f);

        // Round trip on random keys
        for (int i = 0; i < 1000; i++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            run_seq(rk[10], (i % 8 == 0), -1, -1, 1'b0, 1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
